axi_to_axis_tx_engine: RTL and testbench
========================================

Name: axi_to_axis_tx_engine

Overview:
Successor tx handler between the scheduler and the Ethernet MAC AXIS port. It fetches packets from DDR through an AXI4 read master, keeping up to 2**AXI_ID_WIDTH read bursts outstanding, one AXI ID each. It streams returned beats to AXIS with exact tkeep for any packet length. It hands each packet's buffer address back to the memory allocator through a decoupled free queue, so the R channel never stalls on allocator back-pressure unless that queue is full.

Parameters:
AXI_ADDR_WIDTH, 32, AXI/buffer address width
DATA_WIDTH, 64, AXI and AXIS data width; power of two, 64..512
PACKET_SIZE_WIDTH, 11, packet length width in bytes
AXI_ID_WIDTH, 2, ID width; 2**AXI_ID_WIDTH = max outstanding bursts
FREE_FIFO_DEPTH_LOG2, 2, log2 depth of the free-address queue

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
sched_valid_i  in  1  scheduler descriptor valid
sched_addr_i  in  AXI_ADDR_WIDTH  packet buffer address
sched_len_i  in  PACKET_SIZE_WIDTH  packet length in bytes (1..2**PACKET_SIZE_WIDTH-1)
sched_ready_o  out  1  descriptor accepted when valid&ready
m_axi_ar*  out  std  arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arvalid
m_axi_arready_i  in  1
m_axi_rid_i/rdata_i/rresp_i/rlast_i/rvalid_i  in  std
m_axi_rready_o  out  1
m_axis_tvalid_o/tdata_o/tkeep_o/tlast_o  out  std
m_axis_tready_i  in  1
free_addr_o  out  AXI_ADDR_WIDTH  address to release
free_valid_o  out  1  release request
free_ready_i  in  1  allocator accepts
rresp_err_o  out  1  sticky: any rresp != OKAY
idle_o  out  1  no IDs in flight and free queue empty

Behaviour:
- Reset is asynchronous and active-high on rst_i, single clock clk_i. While reset: all valids 0, sched_ready_o 0, rresp_err_o 0, idle_o 1, ID table empty, free queue empty.
- ID table: per ID it holds a valid bit, addr and len. Free ID = lowest-index clear bit.
- sched_ready_o = (AR slot empty or ar accepted this cycle) & a free ID exists.
- On acceptance, an AR slot register loads: arid = free ID, araddr = addr, arlen = ceil(len/BYTES)-1, where BYTES = DATA_WIDTH/8. The ID is marked valid in the same edge.
- arvalid stays high until arready and the AR fields stay stable. One accept per cycle, so back-to-back descriptors are issued with zero bubbles.
- Constant AR fields: arsize = log2(BYTES), arburst INCR, arcache 4'b0010, others 0.
- R path, pure pass-through: tdata = rdata, tvalid = rvalid & gate, rready = tready & gate. gate = 0 only on an rlast beat while the free queue is full.
- Bursts from different IDs must not interleave beat-wise; an rid change is only legal after rlast.
- Beat counter: loaded at the first beat of a burst with table[rid].len, then decremented by BYTES per beat.
- tkeep = all ones, except on the rlast beat, where it is the low (rem==BYTES ? BYTES : rem mod BYTES) bits set. Single-beat packets are covered by the same rule.
- tlast = rlast.
- On the accepted rlast beat: push table[rid].addr into the free queue and clear the ID's valid bit in the same edge. If that ID is allocated in the same cycle, allocation wins and the freed ID becomes available next cycle.
- Free queue: FIFO, free_valid_o = !empty, pop on valid&ready. Push and pop may happen in the same cycle, including when full.
- rresp != 0 on any beat sets rresp_err_o until reset; data is still forwarded.
- States: the R path needs only a first-beat flag (IDLE/BURST). AR is a one-entry slot (EMPTY/FULL).
- Reset mid-burst aborts everything. There is no AXI recovery: the bench must not reset with transactions pending on the slave.

Optional Feature:
TX_STATS_EN.
- When defined: adds outputs stat_pkts_o (32b) and stat_bytes_o (48b), both wrap-around counters cleared on reset.
  - stat_pkts_o increments on each accepted tlast beat.
  - stat_bytes_o adds popcount(tkeep) on each accepted beat.
- When undefined: the ports and logic are absent.

Decomposition:
- Package tx_engine_pkg holds: AXI constants (BURST_INCR, CACHE_MODIFIABLE, RESP_OKAY), a bytes-per-beat function, an arlen calculation function, a last-beat tkeep mask function, and the id_entry_t typedef {valid, addr, len}.
- Sub-module: tx_free_fifo, a generic sync FIFO for the free queue.

Test Plan:
- DATA_WIDTH=64, descriptor addr 0x1000 len 64 -> AR arid 0 arlen 7 arsize 3; 8 beats out; last tkeep 0xFF; free_addr 0x1000.
- len 61 -> arlen 7, last tkeep 0x1F. len 5 -> arlen 0, single beat, tkeep 0x1F, tlast 1.
- Four descriptors back-to-back with arready held high -> arids 0,1,2,3 on consecutive cycles. Fifth descriptor held (sched_ready 0) until the first rlast, then issued on the freed ID.
- free_ready_i held 0 with depth 4 and five packets returned -> the fifth rlast beat stalls (rready 0) until one pop; no data lost.
- rresp=2'b10 on a middle beat -> rresp_err_o rises the next cycle, stays 1, and the stream still completes.
- Reset asserted mid-burst -> all outputs reach reset values asynchronously; idle_o 1.

Source files
------------

// File: rtl/tx_engine_pkg.sv
// Shared types, AXI constants and beat-math helpers for the AXI-to-AXIS tx engine.
package tx_engine_pkg;

  localparam logic [1:0] BURST_INCR       = 2'b01;
  localparam logic [3:0] CACHE_MODIFIABLE = 4'b0010;
  localparam logic [1:0] RESP_OKAY        = 2'b00;

  // ID table entries are stored at these widths; the engine zero-extends into them.
  localparam int ENTRY_ADDR_W = 64;
  localparam int ENTRY_LEN_W  = 16;
  localparam int MAX_BYTES    = 64;

  typedef struct packed {
    logic                    valid;
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_LEN_W-1:0]  len;
  } id_entry_t;

  typedef enum logic {AR_EMPTY = 1'b0, AR_FULL = 1'b1} ar_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_t;

  function automatic int bytes_per_beat(input int data_width);
    return data_width / 8;
  endfunction

  // AXI arlen = number of beats minus one.
  function automatic logic [7:0] calc_arlen(input logic [ENTRY_LEN_W-1:0] len, input int bytes);
    int beats;
    beats = (int'(len) + bytes - 1) / bytes;
    return 8'(beats - 1);
  endfunction

  // Low-order byte lanes valid on the final beat; a full final beat keeps every lane.
  function automatic logic [MAX_BYTES-1:0] last_keep_mask(input logic [ENTRY_LEN_W-1:0] rem,
                                                          input int bytes);
    int n;
    logic [MAX_BYTES-1:0] m;
    n = (int'(rem) == bytes) ? bytes : (int'(rem) % bytes);
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

  function automatic logic [7:0] popcount(input logic [MAX_BYTES-1:0] v);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      c = c + 8'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/tx_free_fifo.sv
// Generic synchronous FIFO; accepts a push while full if a pop happens in the same cycle.
module tx_free_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_MAX = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  // Status flags, qualified handshakes and read port.
  always_comb begin
    full      = (count_r == CNT_MAX);
    empty     = (count_r == '0);
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    pop_data  = mem_r[rd_ptr_r];
  end

  // Storage write; contents need no reset because count_r guards every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axi_to_axis_tx_engine.sv
// Fetches scheduled packets over AXI4 read (one burst per ID) and streams them to AXIS,
// returning each buffer address through a decoupled free queue.
// Optional build macro TX_STATS_EN adds packet/byte counters (stat_pkts_o, stat_bytes_o).
module axi_to_axis_tx_engine
  import tx_engine_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH           = 64,
  parameter int PACKET_SIZE_WIDTH    = 11,
  parameter int AXI_ID_WIDTH         = 2,
  parameter int FREE_FIFO_DEPTH_LOG2 = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sched_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]    sched_addr_i,
  input  logic [PACKET_SIZE_WIDTH-1:0] sched_len_i,
  output logic                         sched_ready_o,
  output logic [AXI_ID_WIDTH-1:0]      m_axi_arid_o,
  output logic [AXI_ADDR_WIDTH-1:0]    m_axi_araddr_o,
  output logic [7:0]                   m_axi_arlen_o,
  output logic [2:0]                   m_axi_arsize_o,
  output logic [1:0]                   m_axi_arburst_o,
  output logic                         m_axi_arlock_o,
  output logic [3:0]                   m_axi_arcache_o,
  output logic [2:0]                   m_axi_arprot_o,
  output logic [3:0]                   m_axi_arqos_o,
  output logic                         m_axi_arvalid_o,
  input  logic                         m_axi_arready_i,
  input  logic [AXI_ID_WIDTH-1:0]      m_axi_rid_i,
  input  logic [DATA_WIDTH-1:0]        m_axi_rdata_i,
  input  logic [1:0]                   m_axi_rresp_i,
  input  logic                         m_axi_rlast_i,
  input  logic                         m_axi_rvalid_i,
  output logic                         m_axi_rready_o,
  output logic                         m_axis_tvalid_o,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata_o,
  output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep_o,
  output logic                         m_axis_tlast_o,
  input  logic                         m_axis_tready_i,
  output logic [AXI_ADDR_WIDTH-1:0]    free_addr_o,
  output logic                         free_valid_o,
  input  logic                         free_ready_i,
  output logic                         rresp_err_o,
`ifdef TX_STATS_EN
  output logic                         idle_o,
  output logic [31:0]                  stat_pkts_o,
  output logic [47:0]                  stat_bytes_o
`else
  output logic                         idle_o
`endif
);

  localparam int BYTES   = bytes_per_beat(DATA_WIDTH);
  localparam int NUM_IDS = 2**AXI_ID_WIDTH;
  localparam logic [2:0] AR_SIZE = 3'($clog2(BYTES));
  localparam logic [ENTRY_LEN_W-1:0] BEAT_BYTES = ENTRY_LEN_W'(BYTES);

  id_entry_t                 id_table_r [NUM_IDS];
  logic [AXI_ID_WIDTH-1:0]   free_id_s;
  logic                      free_found_s;
  logic                      any_valid_s;

  ar_state_t                 ar_state_r, ar_state_next_s;
  logic [AXI_ID_WIDTH-1:0]   ar_id_r;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_r;
  logic [7:0]                ar_len_r;
  logic                      ar_accept_s;
  logic                      sched_accept_s;

  r_state_t                  r_state_r, r_state_next_s;
  logic [ENTRY_LEN_W-1:0]    beat_cnt_r;
  logic [ENTRY_LEN_W-1:0]    rem_s;
  logic [ENTRY_LEN_W-1:0]    cur_len_s;
  logic [ENTRY_ADDR_W-1:0]   cur_addr_s;
  logic [MAX_BYTES-1:0]      last_mask_s;
  logic                      gate_s;
  logic                      r_beat_s;
  logic                      r_last_beat_s;
  logic                      resp_err_r;

  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic                      fifo_pop_s;
  logic                      unused_bits_s;

  // Lowest-index free ID and whether any ID is in flight.
  always_comb begin
    free_id_s    = '0;
    free_found_s = 1'b0;
    any_valid_s  = 1'b0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (!id_table_r[i].valid) begin
        free_id_s    = AXI_ID_WIDTH'(i);
        free_found_s = 1'b1;
      end else begin
        any_valid_s  = 1'b1;
      end
    end
  end

  // ID table: release on the accepted rlast beat, allocation takes priority on the same ID.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_IDS; i++) id_table_r[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IDS; i++) begin
        if (r_last_beat_s && (m_axi_rid_i == AXI_ID_WIDTH'(i))) id_table_r[i].valid <= 1'b0;
        if (sched_accept_s && (free_id_s == AXI_ID_WIDTH'(i))) begin
          id_table_r[i] <= '{valid: 1'b1,
                             addr:  ENTRY_ADDR_W'(sched_addr_i),
                             len:   ENTRY_LEN_W'(sched_len_i)};
        end
      end
    end
  end

  // AR slot state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ar_state_r <= AR_EMPTY;
    else       ar_state_r <= ar_state_next_s;
  end

  // AR slot next state: refills on the same edge it drains so descriptors stream without bubbles.
  always_comb begin
    ar_state_next_s = ar_state_r;
    case (ar_state_r)
      AR_EMPTY: ar_state_next_s = sched_accept_s ? AR_FULL : AR_EMPTY;
      AR_FULL:  ar_state_next_s = (ar_accept_s && !sched_accept_s) ? AR_EMPTY : AR_FULL;
      default:  ar_state_next_s = AR_EMPTY;
    endcase
  end

  // AR slot outputs and descriptor handshake.
  always_comb begin
    m_axi_arvalid_o = (ar_state_r == AR_FULL);
    ar_accept_s     = m_axi_arvalid_o & m_axi_arready_i;
    sched_ready_o   = ~rst_i & ((ar_state_r == AR_EMPTY) | ar_accept_s) & free_found_s;
    sched_accept_s  = sched_valid_i & sched_ready_o;
  end

  // AR slot payload, held stable while arvalid waits for arready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ar_id_r   <= '0;
      ar_addr_r <= '0;
      ar_len_r  <= 8'd0;
    end else if (sched_accept_s) begin
      ar_id_r   <= free_id_s;
      ar_addr_r <= sched_addr_i;
      ar_len_r  <= calc_arlen(ENTRY_LEN_W'(sched_len_i), BYTES);
    end
  end

  assign m_axi_arid_o    = ar_id_r;
  assign m_axi_araddr_o  = ar_addr_r;
  assign m_axi_arlen_o   = ar_len_r;
  assign m_axi_arsize_o  = AR_SIZE;
  assign m_axi_arburst_o = BURST_INCR;
  assign m_axi_arlock_o  = 1'b0;
  assign m_axi_arcache_o = CACHE_MODIFIABLE;
  assign m_axi_arprot_o  = 3'b000;
  assign m_axi_arqos_o   = 4'b0000;

  // R first-beat flag register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state_r <= R_IDLE;
    else       r_state_r <= r_state_next_s;
  end

  // R next state: a burst opens on its first accepted beat and closes on rlast.
  always_comb begin
    r_state_next_s = r_state_r;
    case (r_state_r)
      R_IDLE:  r_state_next_s = (r_beat_s && !m_axi_rlast_i) ? R_BURST : R_IDLE;
      R_BURST: r_state_next_s = r_last_beat_s ? R_IDLE : R_BURST;
      default: r_state_next_s = R_IDLE;
    endcase
  end

  // R pass-through; only the rlast beat is held back, and only while the free queue is full.
  always_comb begin
    cur_len_s       = id_table_r[m_axi_rid_i].len;
    cur_addr_s      = id_table_r[m_axi_rid_i].addr;
    rem_s           = (r_state_r == R_IDLE) ? cur_len_s : beat_cnt_r;
    last_mask_s     = last_keep_mask(rem_s, BYTES);
    gate_s          = ~(m_axi_rlast_i & fifo_full_s);
    m_axis_tvalid_o = ~rst_i & m_axi_rvalid_i & gate_s;
    m_axi_rready_o  = ~rst_i & m_axis_tready_i & gate_s;
    m_axis_tdata_o  = m_axi_rdata_i;
    m_axis_tlast_o  = m_axi_rlast_i;
    m_axis_tkeep_o  = m_axi_rlast_i ? last_mask_s[BYTES-1:0] : {BYTES{1'b1}};
    r_beat_s        = m_axi_rvalid_i & m_axi_rready_o;
    r_last_beat_s   = r_beat_s & m_axi_rlast_i;
    unused_bits_s   = ^{cur_addr_s, last_mask_s};
  end

  // Bytes remaining in the current burst, counted down one beat at a time.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         beat_cnt_r <= '0;
    else if (r_beat_s) beat_cnt_r <= rem_s - BEAT_BYTES;
  end

  // Sticky error flag for any non-OKAY read response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                       resp_err_r <= 1'b0;
    else if (r_beat_s && (m_axi_rresp_i != RESP_OKAY)) resp_err_r <= 1'b1;
  end

  assign rresp_err_o  = resp_err_r;
  assign fifo_pop_s   = free_ready_i;
  assign free_valid_o = ~fifo_empty_s;
  assign idle_o       = ~any_valid_s & fifo_empty_s;

  tx_free_fifo #(
    .WIDTH      (AXI_ADDR_WIDTH),
    .DEPTH_LOG2 (FREE_FIFO_DEPTH_LOG2)
  ) u_free_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (r_last_beat_s),
    .push_data (AXI_ADDR_WIDTH'(cur_addr_s)),
    .full      (fifo_full_s),
    .pop       (fifo_pop_s),
    .pop_data  (free_addr_o),
    .empty     (fifo_empty_s)
  );

`ifdef TX_STATS_EN
  logic [31:0] stat_pkts_r;
  logic [47:0] stat_bytes_r;

  // Wrap-around packet and byte counters over accepted AXIS beats.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_pkts_r  <= 32'd0;
      stat_bytes_r <= 48'd0;
    end else if (r_beat_s) begin
      stat_bytes_r <= stat_bytes_r + 48'(popcount(MAX_BYTES'(m_axis_tkeep_o)));
      if (m_axi_rlast_i) stat_pkts_r <= stat_pkts_r + 32'd1;
    end
  end

  assign stat_pkts_o  = stat_pkts_r;
  assign stat_bytes_o = stat_bytes_r;
`endif

endmodule

// File: tb/tb_axi_to_axis_tx_engine.sv
// Directed self-checking bench for axi_to_axis_tx_engine (DATA_WIDTH=64, 4 IDs, free queue depth 4).
module tb_axi_to_axis_tx_engine;

  logic        clk;
  logic        rst;
  logic        sched_valid;
  logic [31:0] sched_addr;
  logic [10:0] sched_len;
  logic        sched_ready;
  logic [1:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        arvalid;
  logic        arready;
  logic [1:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        tvalid;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tready;
  logic [31:0] free_addr;
  logic        free_valid;
  logic        free_ready;
  logic        rresp_err;
  logic        idle;
`ifdef TX_STATS_EN
  logic [31:0] stat_pkts;
  logic [47:0] stat_bytes;
`endif

  int checks   = 0;
  int failures = 0;

  axi_to_axis_tx_engine dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .sched_valid_i   (sched_valid),
    .sched_addr_i    (sched_addr),
    .sched_len_i     (sched_len),
    .sched_ready_o   (sched_ready),
    .m_axi_arid_o    (arid),
    .m_axi_araddr_o  (araddr),
    .m_axi_arlen_o   (arlen),
    .m_axi_arsize_o  (arsize),
    .m_axi_arburst_o (arburst),
    .m_axi_arlock_o  (arlock),
    .m_axi_arcache_o (arcache),
    .m_axi_arprot_o  (arprot),
    .m_axi_arqos_o   (arqos),
    .m_axi_arvalid_o (arvalid),
    .m_axi_arready_i (arready),
    .m_axi_rid_i     (rid),
    .m_axi_rdata_i   (rdata),
    .m_axi_rresp_i   (rresp),
    .m_axi_rlast_i   (rlast),
    .m_axi_rvalid_i  (rvalid),
    .m_axi_rready_o  (rready),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tdata_o  (tdata),
    .m_axis_tkeep_o  (tkeep),
    .m_axis_tlast_o  (tlast),
    .m_axis_tready_i (tready),
    .free_addr_o     (free_addr),
    .free_valid_o    (free_valid),
    .free_ready_i    (free_ready),
    .rresp_err_o     (rresp_err),
`ifdef TX_STATS_EN
    .idle_o          (idle),
    .stat_pkts_o     (stat_pkts),
    .stat_bytes_o    (stat_bytes)
`else
    .idle_o          (idle)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one descriptor, check the AR request it produces, then complete the AR handshake.
  task automatic issue(input logic [31:0] addr, input logic [10:0] len,
                       input logic [1:0] exp_id, input logic [7:0] exp_arlen);
    @(negedge clk);
    sched_valid = 1'b1; sched_addr = addr; sched_len = len;
    #1 chk("sched_ready", 64'(sched_ready), 64'h1);
    @(posedge clk);
    @(negedge clk);
    sched_valid = 1'b0;
    chk("arvalid", 64'(arvalid), 64'h1);
    chk("arid", 64'(arid), 64'(exp_id));
    chk("araddr", 64'(araddr), 64'(addr));
    chk("arlen", 64'(arlen), 64'(exp_arlen));
    chk("arsize", 64'(arsize), 64'h3);
    chk("arburst_cache", 64'({arburst, arcache, arlock, arprot, arqos}), 64'({2'b01, 4'b0010, 1'b0, 3'b000, 4'b0000}));
    chk("idle_busy", 64'(idle), 64'h0);
    arready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arready = 1'b0;
    chk("arvalid_drop", 64'(arvalid), 64'h0);
  endtask

  // Drive one R beat (left valid) and check the AXIS side before the accepting edge.
  task automatic beat(input logic [1:0] id, input logic [63:0] data, input logic last,
                      input logic [1:0] resp, input logic [7:0] exp_keep);
    @(negedge clk);
    rid = id; rdata = data; rlast = last; rresp = resp; rvalid = 1'b1;
    #1;
    chk("tvalid", 64'(tvalid), 64'h1);
    chk("rready", 64'(rready), 64'h1);
    chk("tdata", tdata, data);
    chk("tkeep", 64'(tkeep), 64'(exp_keep));
    chk("tlast", 64'(tlast), 64'(last));
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; sched_valid = 1'b0; sched_addr = 32'h0; sched_len = 11'd0;
    arready = 1'b0; rid = 2'd0; rdata = 64'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    tready = 1'b1; free_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sched_ready", 64'(sched_ready), 64'h0);
    chk("rst_arvalid", 64'(arvalid), 64'h0);
    chk("rst_tvalid", 64'(tvalid), 64'h0);
    chk("rst_rready", 64'(rready), 64'h0);
    chk("rst_free_valid", 64'(free_valid), 64'h0);
    chk("rst_idle", 64'(idle), 64'h1);
    chk("rst_rresp_err", 64'(rresp_err), 64'h0);
    rst = 1'b0;

    // 64-byte packet: 8 full beats, address freed afterwards
    issue(32'h1000, 11'd64, 2'd0, 8'd7);
    for (int i = 0; i < 8; i++) beat(2'd0, 64'h1100_0000_0000_0000 + 64'(i), (i == 7), 2'b00, 8'hFF);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    chk("t1_free_valid", 64'(free_valid), 64'h1);
    chk("t1_free_addr", 64'(free_addr), 64'h1000);
    chk("t1_idle_pending", 64'(idle), 64'h0);
    free_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    free_ready = 1'b0;
    chk("t1_free_empty", 64'(free_valid), 64'h0);
    chk("t1_idle", 64'(idle), 64'h1);

    // 61-byte packet: last beat carries 5 bytes
    free_ready = 1'b1;
    issue(32'h2000, 11'd61, 2'd0, 8'd7);
    for (int i = 0; i < 8; i++) beat(2'd0, 64'h2200_0000_0000_0000 + 64'(i), (i == 7), 2'b00, (i == 7) ? 8'h1F : 8'hFF);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    chk("t2_free_valid", 64'(free_valid), 64'h1);
    chk("t2_free_addr", 64'(free_addr), 64'h2000);

    // 5-byte packet: single beat
    issue(32'h3000, 11'd5, 2'd0, 8'd0);
    beat(2'd0, 64'h3333_4444_5555_6666, 1'b1, 2'b00, 8'h1F);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    chk("t3_free_addr", 64'(free_addr), 64'h3000);
    @(negedge clk);
    chk("t3_idle", 64'(idle), 64'h1);
    free_ready = 1'b0;

    // Four back-to-back descriptors, fifth held until an ID is freed
    arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("t4_arvalid", 64'(arvalid), 64'h1);
        chk("t4_arid", 64'(arid), 64'(i - 1));
      end
      sched_valid = 1'b1; sched_addr = 32'(256 * (i + 1)); sched_len = 11'd16;
      #1 chk("t4_sched_ready", 64'(sched_ready), 64'h1);
      @(posedge clk);
    end
    @(negedge clk);
    chk("t4_arid3", 64'(arid), 64'h3);
    chk("t4_araddr3", 64'(araddr), 64'h400);
    sched_addr = 32'h500; sched_len = 11'd16;
    #1 chk("t4_full_ready", 64'(sched_ready), 64'h0);
    @(posedge clk);
    @(negedge clk);
    chk("t4_ar_drained", 64'(arvalid), 64'h0);
    chk("t4_still_held", 64'(sched_ready), 64'h0);
    beat(2'd0, 64'hA0, 1'b0, 2'b00, 8'hFF);
    beat(2'd0, 64'hA1, 1'b1, 2'b00, 8'hFF);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    #1 chk("t4_freed_ready", 64'(sched_ready), 64'h1);
    @(posedge clk);
    @(negedge clk);
    sched_valid = 1'b0;
    chk("t5_arvalid", 64'(arvalid), 64'h1);
    chk("t5_arid", 64'(arid), 64'h0);
    chk("t5_araddr", 64'(araddr), 64'h500);

    // Free queue full: fifth rlast stalls until one pop
    for (int i = 1; i < 4; i++) begin
      beat(2'(i), 64'(16 * i), 1'b0, 2'b00, 8'hFF);
      beat(2'(i), 64'(16 * i + 1), 1'b1, 2'b00, 8'hFF);
    end
    arready = 1'b0;
    beat(2'd0, 64'hB0, 1'b0, 2'b00, 8'hFF);
    @(negedge clk);
    rid = 2'd0; rdata = 64'hB1; rlast = 1'b1; rvalid = 1'b1;
    #1;
    chk("t5_stall_rready", 64'(rready), 64'h0);
    chk("t5_stall_tvalid", 64'(tvalid), 64'h0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_stall_hold", 64'(rready), 64'h0);
    free_ready = 1'b1;
    #1 chk("t5_pop_addr", 64'(free_addr), 64'h100);
    @(posedge clk);
    @(negedge clk);
    free_ready = 1'b0;
    #1;
    chk("t5_release_rready", 64'(rready), 64'h1);
    chk("t5_release_tvalid", 64'(tvalid), 64'h1);
    chk("t5_release_tdata", tdata, 64'hB1);
    chk("t5_release_tlast", 64'(tlast), 64'h1);
    @(posedge clk);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("t5_drain_valid", 64'(free_valid), 64'h1);
      chk("t5_drain_addr", 64'(free_addr), 64'(256 * (j + 2)));
      free_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    free_ready = 1'b0;
    chk("t5_drained", 64'(free_valid), 64'h0);
    chk("t5_idle", 64'(idle), 64'h1);

    // Error response mid-burst
    free_ready = 1'b1;
    issue(32'h6000, 11'd24, 2'd0, 8'd2);
    beat(2'd0, 64'hC0, 1'b0, 2'b00, 8'hFF);
    #2 chk("t6_err_before", 64'(rresp_err), 64'h0);
    beat(2'd0, 64'hC1, 1'b0, 2'b10, 8'hFF);
    #2 chk("t6_err_rise", 64'(rresp_err), 64'h1);
    beat(2'd0, 64'hC2, 1'b1, 2'b00, 8'hFF);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    chk("t6_free_addr", 64'(free_addr), 64'h6000);
    @(negedge clk);
    chk("t6_err_sticky", 64'(rresp_err), 64'h1);
    chk("t6_idle", 64'(idle), 64'h1);

    // Reset mid-burst
    issue(32'h7000, 11'd32, 2'd0, 8'd3);
    beat(2'd0, 64'hD0, 1'b0, 2'b00, 8'hFF);
    beat(2'd0, 64'hD1, 1'b0, 2'b00, 8'hFF);
    #2 rst = 1'b1;
    #1;
    chk("t7_tvalid", 64'(tvalid), 64'h0);
    chk("t7_rready", 64'(rready), 64'h0);
    chk("t7_sched_ready", 64'(sched_ready), 64'h0);
    chk("t7_arvalid", 64'(arvalid), 64'h0);
    chk("t7_free_valid", 64'(free_valid), 64'h0);
    chk("t7_idle", 64'(idle), 64'h1);
    chk("t7_rresp_err", 64'(rresp_err), 64'h0);
    rvalid = 1'b0;
    free_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t7_post_ready", 64'(sched_ready), 64'h1);
    issue(32'h8000, 11'd8, 2'd0, 8'd0);
    beat(2'd0, 64'hE0, 1'b1, 2'b00, 8'hFF);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    chk("t7_post_free", 64'(free_addr), 64'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
